// File: rtl/gemm_dot_accum_if.sv
// Operand/result stream bundle for the GEMM dot-product accumulator.
// master drives operands and result-ready; slave is the accumulator side.
interface gemm_dot_accum_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_ovf
  );
endinterface

// File: rtl/gemm_dot_accum.sv
// Streaming Q2.14 dot-product accumulator: multiply stage, rescale/round/saturate
// accumulate stage, and a one-result holding register with valid/ready handoff.
module gemm_dot_accum #(
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 32,
  parameter int FRAC_BITS = 14,
  parameter int ROUND     = 1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  gemm_dot_accum_if.slave      bus
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int EXT_W  = (ACC_W + 1 > PROD_W + 1) ? ACC_W + 1 : PROD_W + 1;
  localparam int SUM_W  = EXT_W + 1;
  localparam logic [PROD_W:0] RND_ADD =
    (ROUND != 0) ? ((PROD_W + 1)'(1) << (FRAC_BITS - 1)) : '0;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {S_ACC, S_FLUSH, S_HOLD} state_t;

  state_t                    state_q, state_d;
  logic                      in_ready_q, in_ready_d;
  logic signed [PROD_W-1:0]  prod_q, prod_d;
  logic                      last_q, last_d;
  logic                      pv_q, pv_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      ovf_q, ovf_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0]   out_acc_q, out_acc_d;
  logic [CNT_W-1:0]          out_count_q, out_count_d;
  logic                      out_ovf_q, out_ovf_d;

  logic                      accept;
  logic signed [PROD_W:0]    rnd_prod;
  logic signed [PROD_W:0]    term;
  logic signed [SUM_W-1:0]   sum;
  logic [SUM_W-ACC_W:0]      sum_hi;
  logic                      clamp;
  logic signed [ACC_W-1:0]   sat;
  logic [CNT_W-1:0]          cnt_inc;

  assign accept = bus.in_valid && in_ready_q;

  // Sum is wide enough that it never wraps; out of range shows as non-uniform top bits.
  always_comb begin
    rnd_prod = {prod_q[PROD_W-1], prod_q} + RND_ADD;
    term     = rnd_prod >>> FRAC_BITS;
    sum      = SUM_W'(acc_q) + SUM_W'(term);
    sum_hi   = sum[SUM_W-1:ACC_W-1];
    clamp    = !((&sum_hi) || !(|sum_hi));
    sat      = clamp ? (sum[SUM_W-1] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
    cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  end

  always_comb begin
    // NOTE: every _d takes its hold value first, so no branch can leave one unassigned and infer a latch.
    state_d     = state_q;
    prod_d      = prod_q;
    last_d      = last_q;
    pv_d        = 1'b0;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    if (accept) begin
      prod_d = PROD_W'($signed(bus.in_a)) * PROD_W'($signed(bus.in_b));
      last_d = bus.in_last;
      pv_d   = 1'b1;
    end

    if (pv_q) begin
      if (last_q) begin
        out_acc_d   = sat;
        out_count_d = cnt_inc;
        out_ovf_d   = ovf_q | clamp;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        acc_d = sat;
        cnt_d = cnt_inc;
        ovf_d = ovf_q | clamp;
      end
    end

    case (state_q)
      S_ACC:   if (accept && bus.in_last) state_d = S_FLUSH;
      S_FLUSH: if (pv_q && last_q) state_d = S_HOLD;
      S_HOLD: begin
        if (bus.out_ready) begin
          state_d     = S_ACC;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = S_ACC;
    endcase

    in_ready_d = (state_d == S_ACC);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
    if (rst) begin
      state_q     <= S_ACC;
      in_ready_q  <= 1'b1;
      prod_q      <= '0;
      last_q      <= 1'b0;
      pv_q        <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      prod_q      <= prod_d;
      last_q      <= last_d;
      pv_q        <= pv_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = out_acc_q;
  assign bus.out_count = out_count_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule
